// File: rtl/sar_ctrl_core.sv
// sar_ctrl_core -- behavioural SAR conversion controller.
//
// Samples a differential analog input on a start request, then resolves one
// output bit per clock (MSB first) against a binary-weighted threshold
// derived from the latched reference span. It also checks the input common
// mode and the reference polarity at sampling time.
//
// Ports
//   clk      : clock, all state updates on the rising edge
//   rst      : synchronous active-high reset
//   start    : conversion request (ignored while busy)
//   vip/vin  : positive / negative analog input (volts)
//   vcm      : common-mode reference (volts)
//   vrefp/vrefn : positive / negative reference (volts)
//   busy     : conversion in progress
//   dout     : last completed code, unsigned offset-binary
//   valid    : one-cycle pulse when dout updates
//   cm_err   : common-mode check failed for the code on dout
//   ref_err  : reference span was <= 0 for the code on dout (dout forced 0)
module sar_ctrl_core #(
    parameter int  NBIT   = 8,
    parameter real CM_TOL = 0.05
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  real             vip,
    input  real             vin,
    input  real             vcm,
    input  real             vrefp,
    input  real             vrefn,
    output logic            busy,
    output logic [NBIT-1:0] dout,
    output logic            valid,
    output logic            cm_err,
    output logic            ref_err
);
    localparam int BW = (NBIT > 1) ? $clog2(NBIT) : 1;

    typedef enum logic {IDLE, CONV} state_t;

    state_t          state, state_n;
    real             vd_q, vr_q;
    logic            cm_bad_q, ref_bad_q;
    logic [NBIT-1:0] trial, trial_n, probe, bit_mask;
    logic [BW-1:0]   bidx;
    real             thr, cm_dev;
    logic            last_bit;

    // Threshold for the bit under test: the trial code with that bit set,
    // mapped from [0, 2^NBIT) onto [-vr, +vr).
    always_comb begin
        state_n  = state;
        bit_mask = NBIT'(1) << bidx;
        probe    = trial | bit_mask;
        thr      = vr_q * (2.0 * real'(probe) / real'(2 ** NBIT) - 1.0);
        trial_n  = trial;
        last_bit = (bidx == '0);
        cm_dev   = (vip + vin) / 2.0 - vcm;
        case (state)
            IDLE: if (start) state_n = CONV;
            CONV: begin
                trial_n = (vd_q >= thr) ? probe : (trial & ~bit_mask);
                if (last_bit) state_n = IDLE;
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            busy      <= 1'b0;
            valid     <= 1'b0;
            dout      <= '0;
            cm_err    <= 1'b0;
            ref_err   <= 1'b0;
            trial     <= '0;
            bidx      <= '0;
            vd_q      <= 0.0;
            vr_q      <= 0.0;
            cm_bad_q  <= 1'b0;
            ref_bad_q <= 1'b0;
        end else begin
            state <= state_n;
            valid <= 1'b0;
            case (state)
                IDLE: if (start) begin
                    // Freeze the analog inputs; only these copies feed the
                    // bit trials, so later input motion cannot disturb them.
                    vd_q      <= vip - vin;
                    vr_q      <= vrefp - vrefn;
                    cm_bad_q  <= (cm_dev > CM_TOL) || (cm_dev < -CM_TOL);
                    ref_bad_q <= (vrefp - vrefn) <= 0.0;
                    trial     <= '0;
                    bidx      <= BW'(NBIT - 1);
                    busy      <= 1'b1;
                end
                CONV: begin
                    trial <= trial_n;
                    bidx  <= bidx - BW'(1);
                    if (last_bit) begin
                        // A bad reference still runs all trials but reports 0.
                        dout    <= ref_bad_q ? '0 : trial_n;
                        valid   <= 1'b1;
                        busy    <= 1'b0;
                        cm_err  <= cm_bad_q;
                        ref_err <= ref_bad_q;
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_sar_ctrl_core.sv
// tb_sar_ctrl_core -- directed self-checking bench for sar_ctrl_core
// (NBIT=8, vcm=0.5, vrefp=0.6, vrefn=0.4 unless a test changes them).
`timescale 1ns/1ps
module tb_sar_ctrl_core;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start = 1'b0;
    real        vip = 0.5, vin = 0.5, vcm = 0.5, vrefp = 0.6, vrefn = 0.4;
    logic       busy, valid, cm_err, ref_err;
    logic [7:0] dout;

    int checks = 0;
    int errors = 0;

    sar_ctrl_core #(.NBIT(8), .CM_TOL(0.05)) dut (
        .clk(clk), .rst(rst), .start(start),
        .vip(vip), .vin(vin), .vcm(vcm), .vrefp(vrefp), .vrefn(vrefn),
        .busy(busy), .dout(dout), .valid(valid),
        .cm_err(cm_err), .ref_err(ref_err)
    );

    always #5 clk = ~clk;

    // Advance one rising edge; outputs are then sampled 1 ns later.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Start one conversion and wait for valid; reports the edges from the
    // start edge to valid (20 means it never came).
    task automatic do_conv(input real vp, input real vn, output logic [7:0] d,
                           output logic c, output logic r, output int lat);
        vip = vp; vin = vn; start = 1'b1;
        step();
        start = 1'b0;
        lat = 20;
        for (int i = 1; i < 20; i++) begin
            step();
            if (valid) begin lat = i; break; end
        end
        d = dout; c = cm_err; r = ref_err;
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 1'b1;
        step(); step();
        checks++;
        if ({busy, valid, dout, cm_err, ref_err} !== 12'h0) begin
            errors++;
            $display("FAIL reset_outputs got busy=%b valid=%b dout=%0d cm=%b ref=%b want all 0",
                     busy, valid, dout, cm_err, ref_err);
        end
        rst = 1'b0; start = 1'b0;
        step();
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL reset_start_ignored got busy=%b want 0", busy);
        end
    endtask

    task automatic test_midscale();
        vip = 0.5; vin = 0.5; start = 1'b1;
        step();
        start = 1'b0;
        for (int i = 0; i < 8; i++) begin
            checks++;
            if (busy !== 1'b1 || valid !== 1'b0) begin
                errors++;
                $display("FAIL mid_busy edge k+%0d got busy=%b valid=%b want 1/0", i, busy, valid);
            end
            if (i < 7) step();
        end
        step();
        checks++;
        if (valid !== 1'b1 || busy !== 1'b0 || dout !== 8'd128 || cm_err !== 1'b0 || ref_err !== 1'b0) begin
            errors++;
            $display("FAIL mid_result got valid=%b busy=%b dout=%0d cm=%b ref=%b want 1/0/128/0/0",
                     valid, busy, dout, cm_err, ref_err);
        end
        step();
        checks++;
        if (valid !== 1'b0 || dout !== 8'd128) begin
            errors++;
            $display("FAIL mid_hold got valid=%b dout=%0d want 0/128", valid, dout);
        end
    endtask

    task automatic test_codes();
        real        vp[3] = '{0.55, 0.7, 0.3};
        real        vn[3] = '{0.45, 0.3, 0.7};
        logic [7:0] exp[3] = '{8'd192, 8'd255, 8'd0};
        logic [7:0] d; logic c, r; int lat;
        for (int i = 0; i < 3; i++) begin
            do_conv(vp[i], vn[i], d, c, r, lat);
            checks++;
            if (d !== exp[i] || lat != 8 || c !== 1'b0 || r !== 1'b0) begin
                errors++;
                $display("FAIL code_%0d got dout=%0d lat=%0d cm=%b ref=%b want %0d/8/0/0",
                         i, d, lat, c, r, exp[i]);
            end
        end
    endtask

    task automatic test_freeze_busy_start();
        int nvalid = 0;
        logic [7:0] d = 8'hxx;
        vip = 0.55; vin = 0.45; start = 1'b1;
        step();
        start = 1'b0; vip = 0.3;
        for (int i = 1; i <= 20; i++) begin
            start = (i == 4);
            step();
            if (valid) begin nvalid++; d = dout; end
        end
        start = 1'b0;
        checks++;
        if (nvalid != 1 || d !== 8'd192) begin
            errors++;
            $display("FAIL freeze got valids=%0d dout=%0d want 1/192", nvalid, d);
        end
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL busy_start_ignored got busy=%b want 0", busy);
        end
        vip = 0.5; vin = 0.5;
    endtask

    task automatic test_back_to_back();
        real        np[3] = '{0.7, 0.3, 0.5};
        real        nn[3] = '{0.3, 0.7, 0.5};
        logic [7:0] exp[3] = '{8'd192, 8'd255, 8'd0};
        int gap;
        vip = 0.55; vin = 0.45; start = 1'b1;
        step();
        for (int c = 0; c < 3; c++) begin
            vip = np[c]; vin = nn[c];
            if (c == 2) start = 1'b0;
            gap = 30;
            for (int i = 1; i < 30; i++) begin
                step();
                if (valid) begin gap = i; break; end
            end
            checks++;
            if (gap != 8 || dout !== exp[c]) begin
                errors++;
                $display("FAIL b2b_%0d got lat=%0d dout=%0d want 8/%0d", c, gap, dout, exp[c]);
            end
            if (c < 2) step();
        end
        step();
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL b2b_stop got busy=%b want 0", busy);
        end
    endtask

    task automatic test_error_flags();
        logic [7:0] d; logic c, r; int lat;
        do_conv(0.6, 0.6, d, c, r, lat);
        checks++;
        if (d !== 8'd128 || c !== 1'b1 || r !== 1'b0 || lat != 8) begin
            errors++;
            $display("FAIL cm_err got dout=%0d cm=%b ref=%b lat=%0d want 128/1/0/8", d, c, r, lat);
        end
        step(); step();
        checks++;
        if (cm_err !== 1'b1 || dout !== 8'd128) begin
            errors++;
            $display("FAIL cm_hold got cm=%b dout=%0d want 1/128", cm_err, dout);
        end
        vrefp = 0.4; vrefn = 0.6;
        do_conv(0.5, 0.5, d, c, r, lat);
        checks++;
        if (d !== 8'd0 || c !== 1'b0 || r !== 1'b1 || lat != 8) begin
            errors++;
            $display("FAIL ref_err got dout=%0d cm=%b ref=%b lat=%0d want 0/0/1/8", d, c, r, lat);
        end
        vrefp = 0.6; vrefn = 0.4;
        do_conv(0.55, 0.45, d, c, r, lat);
        checks++;
        if (d !== 8'd192 || c !== 1'b0 || r !== 1'b0) begin
            errors++;
            $display("FAIL flags_clear got dout=%0d cm=%b ref=%b want 192/0/0", d, c, r);
        end
    endtask

    task automatic test_reset_midconv();
        int nvalid = 0;
        logic [7:0] d; logic c, r; int lat;
        do_conv(0.6, 0.6, d, c, r, lat);
        vip = 0.55; vin = 0.45; start = 1'b1;
        step();
        start = 1'b0;
        step(); step(); step();
        rst = 1'b1;
        step();
        checks++;
        if ({busy, valid, dout, cm_err, ref_err} !== 12'h0) begin
            errors++;
            $display("FAIL rst_mid got busy=%b valid=%b dout=%0d cm=%b ref=%b want all 0",
                     busy, valid, dout, cm_err, ref_err);
        end
        rst = 1'b0;
        for (int i = 0; i < 12; i++) begin
            step();
            if (valid) nvalid++;
        end
        checks++;
        if (nvalid != 0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL rst_abort got valids=%0d busy=%b want 0/0", nvalid, busy);
        end
        do_conv(0.7, 0.3, d, c, r, lat);
        checks++;
        if (d !== 8'd255 || lat != 8) begin
            errors++;
            $display("FAIL rst_restart got dout=%0d lat=%0d want 255/8", d, lat);
        end
    endtask

    initial begin
        test_reset();
        test_midscale();
        test_codes();
        test_freeze_busy_start();
        test_back_to_back();
        test_error_flags();
        test_reset_midconv();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
